// File: rtl/sigmoid_lut_loader_if.sv
// Handshake and LUT write-port bundle for the sigmoid LUT loader.
// slave: the loader's view. It takes the control and byte stream, and it drives the LUT write port and status.
// master: the view of the configuration side and the LUT side that face the loader.
interface sigmoid_lut_loader_if #(
    parameter int data_width              = 16,
    parameter int weight_sigmoid_in_width = 10
);
    logic                               start;
    logic                               abort;
    logic [7:0]                         byte_in;
    logic                               byte_valid;
    logic                               byte_ready;
    logic                               lut_wr_en;
    logic [weight_sigmoid_in_width-1:0] lut_wr_addr;
    logic [data_width-1:0]              lut_wr_data;
    logic                               busy;
    logic                               done;
    logic [data_width-1:0]              checksum;

    modport slave (
        input  start, abort, byte_in, byte_valid,
        output byte_ready, lut_wr_en, lut_wr_addr, lut_wr_data, busy, done, checksum
    );

    modport master (
        output start, abort, byte_in, byte_valid,
        input  byte_ready, lut_wr_en, lut_wr_addr, lut_wr_data, busy, done, checksum
    );
endinterface

// File: rtl/sigmoid_lut_loader.sv
// Runtime writer for the sigmoid activation LUT. Little-endian bytes are assembled into LUT words,
// which are written in ascending address order 0..2**weight_sigmoid_in_width-1.
// Ports: clk, rst_n (async, active-low), and bus (slave modport) carrying start/abort, the byte
// stream handshake, the LUT write port, and the busy/done/checksum status.
// Latency: last byte of a word accepted -> lut_wr_en one cycle later. Throughput is 1 byte/cycle.
// Backpressure: byte_ready is a registered copy of "in LOAD". Bytes offered outside LOAD are dropped.
module sigmoid_lut_loader #(
    parameter int data_width              = 16,
    parameter int weight_sigmoid_in_width = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sigmoid_lut_loader_if.slave  bus
);
    localparam int BPW = (data_width + 7) / 8;
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int AW  = weight_sigmoid_in_width;
    localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic                  ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic [IW-1:0]         idx_q;
    logic [AW-1:0]         addr_q;
    logic [BPW*8-1:0]      word_q;
    logic                  wr_en_q;
    logic [AW-1:0]         wr_addr_q;
    logic [data_width-1:0] wr_data_q;
    logic [data_width-1:0] csum_q;

    logic                  xfer;
    logic [BPW*8-1:0]      word_next;

    assign xfer = bus.byte_valid && ready_q;

    // Partial word with the incoming byte merged into its slot. This lets the final byte go
    // straight into the write register without an extra assembly cycle.
    always_comb begin
        word_next = word_q;
        for (int i = 0; i < BPW; i++) begin
            if (idx_q == IW'(i)) begin
                word_next[8*i +: 8] = bus.byte_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= '0;
            addr_q    <= '0;
            word_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            csum_q    <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state   <= LOAD;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        idx_q   <= '0;
                        addr_q  <= '0;
                        csum_q  <= '0;
                    end
                end
                LOAD: begin
                    // abort wins over a byte accepted in the same cycle, so a partial word is dropped.
                    // The checksum is kept until the next start clears it.
                    if (bus.abort) begin
                        state   <= IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        addr_q  <= '0;
                    end else if (xfer) begin
                        word_q <= word_next;
                        if (idx_q == LAST_IDX) begin
                            idx_q     <= '0;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= word_next[data_width-1:0];
                            csum_q    <= csum_q ^ word_next[data_width-1:0];
                            addr_q    <= addr_q + AW'(1);
                            // The final write and the move to DONE happen on the same edge.
                            // The address wraps to 0 here.
                            if (addr_q == {AW{1'b1}}) begin
                                state   <= DONE;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready  = ready_q;
    assign bus.lut_wr_en   = wr_en_q;
    assign bus.lut_wr_addr = wr_addr_q;
    assign bus.lut_wr_data = wr_data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.checksum    = csum_q;
endmodule

// File: tb/tb_sigmoid_lut_loader.sv
module tb_sigmoid_lut_loader;
    localparam int DW = 16;
    localparam int AW = 10;

    logic clk;
    logic rst_n;

    sigmoid_lut_loader_if #(.data_width(DW), .weight_sigmoid_in_width(AW)) bus();

    sigmoid_lut_loader #(.data_width(DW), .weight_sigmoid_in_width(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int busy_drop = 0;
    bit track_busy = 1'b0;
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock, then sample 1 time unit after the edge and log any write strobe.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.lut_wr_en === 1'b1) begin
            wr_addr_q.push_back(bus.lut_wr_addr);
            wr_data_q.push_back(bus.lut_wr_data);
        end
        if (track_busy && bus.busy !== 1'b1 &&
            !(bus.lut_wr_en === 1'b1 && bus.lut_wr_addr === {AW{1'b1}}))
            busy_drop++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        step();
        bus.byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) step();
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send_byte(w[7:0], 0);
        send_byte(w[15:8], gap);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] model_csum;
        int addr_errs;
        int data_errs;

        bus.start = 1'b0; bus.abort = 1'b0; bus.byte_in = 8'h00; bus.byte_valid = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        // Reset state, checked before any clock edge
        check("rst_byte_ready", bus.byte_ready, 0);
        check("rst_wr_en", bus.lut_wr_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_checksum", bus.checksum, 0);
        check("rst_wr_addr", bus.lut_wr_addr, 0);
        check("rst_wr_data", bus.lut_wr_data, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // A byte offered in IDLE is dropped
        bus.byte_valid = 1'b1; bus.byte_in = 8'hA5;
        repeat (3) step();
        bus.byte_valid = 1'b0;
        check("idle_byte_ready", bus.byte_ready, 0);
        check("idle_no_write", wr_addr_q.size(), 0);

        // A single word, little-endian
        bus.start = 1'b1; step(); bus.start = 1'b0;
        check("load_byte_ready", bus.byte_ready, 1);
        check("load_busy", bus.busy, 1);
        send_byte(8'h34, 0);
        check("w0_no_early_write", bus.lut_wr_en, 0);
        send_byte(8'h12, 0);
        check("w0_wr_en", bus.lut_wr_en, 1);
        check("w0_wr_addr", bus.lut_wr_addr, 0);
        check("w0_wr_data", bus.lut_wr_data, 16'h1234);
        check("w0_checksum", bus.checksum, 16'h1234);
        step(); step();
        check("w0_strobe_drop", bus.lut_wr_en, 0);
        check("w0_data_hold", bus.lut_wr_data, 16'h1234);
        check("w0_one_strobe", wr_addr_q.size(), 1);

        // Abort after words 0..4 and one byte of word 5
        for (int k = 1; k <= 4; k++) send_word(16'h1111 * 16'(k), 1);
        send_byte(8'hAA, 0);
        bus.abort = 1'b1; bus.byte_in = 8'hBB; bus.byte_valid = 1'b1;
        step();
        bus.abort = 1'b0; bus.byte_valid = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_byte_ready", bus.byte_ready, 0);
        check("abort_done", bus.done, 0);
        repeat (3) step();
        check("abort_writes", wr_addr_q.size(), 5);
        check("abort_last_addr", wr_addr_q[wr_addr_q.size()-1], 4);
        check("abort_checksum_kept", bus.checksum, 16'h5670);
        // A second abort in IDLE has no effect
        bus.abort = 1'b1; step(); bus.abort = 1'b0;
        check("idle_abort_busy", bus.busy, 0);

        // Full load restarting from address 0, with random gaps and a start pulse mid-load
        wr_addr_q.delete(); wr_data_q.delete();
        bus.start = 1'b1; step(); bus.start = 1'b0;
        check("restart_checksum_clear", bus.checksum, 0);
        check("restart_busy", bus.busy, 1);
        track_busy = 1'b1;
        for (int k = 0; k < 1024; k++) begin
            w = 16'(k);
            if (k == 600) bus.start = 1'b1;
            send_byte(w[7:0], $urandom_range(0, 2));
            bus.start = 1'b0;
            send_byte(w[15:8], (k == 1023) ? 0 : $urandom_range(0, 2));
        end
        track_busy = 1'b0;
        check("full_last_wr_en", bus.lut_wr_en, 1);
        check("full_done_at_last_write", bus.done, 1);
        check("full_strobe_count", wr_addr_q.size(), 1024);
        addr_errs = 0; data_errs = 0;
        for (int i = 0; i < wr_addr_q.size() && i < 1024; i++) begin
            if (wr_addr_q[i] !== AW'(i)) addr_errs++;
            if (wr_data_q[i] !== DW'(i)) data_errs++;
        end
        check("full_addr_sequence", addr_errs, 0);
        check("full_data_sequence", data_errs, 0);
        check("full_busy_throughout", busy_drop, 0);
        step();
        check("full_done", bus.done, 1);
        check("full_byte_ready", bus.byte_ready, 0);
        check("full_busy_low", bus.busy, 0);
        check("full_checksum", bus.checksum, 16'h0000);
        bus.byte_valid = 1'b1; bus.byte_in = 8'h77;
        repeat (3) step();
        bus.byte_valid = 1'b0;
        check("done_no_write", wr_addr_q.size(), 1024);
        check("done_held", bus.done, 1);

        // start in DONE reloads from address 0
        wr_addr_q.delete(); wr_data_q.delete();
        bus.start = 1'b1; step(); bus.start = 1'b0;
        check("reload_busy", bus.busy, 1);
        check("reload_done", bus.done, 0);
        check("reload_byte_ready", bus.byte_ready, 1);
        model_csum = '0;
        for (int k = 0; k < 300; k++) begin
            w = 16'(3 * k + 7);
            model_csum ^= w;
            send_word(w, 0);
        end
        check("reload_count", wr_addr_q.size(), 300);
        check("reload_first_addr", wr_addr_q[0], 0);
        check("reload_first_data", wr_data_q[0], 16'h0007);
        check("reload_last_addr", wr_addr_q[wr_addr_q.size()-1], 299);
        check("reload_checksum", bus.checksum, model_csum);

        // Asynchronous reset during word 300
        send_byte(8'hC3, 0);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_byte_ready", bus.byte_ready, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_wr_en", bus.lut_wr_en, 0);
        check("midrst_wr_addr", bus.lut_wr_addr, 0);
        check("midrst_wr_data", bus.lut_wr_data, 0);
        check("midrst_checksum", bus.checksum, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        wr_addr_q.delete(); wr_data_q.delete();
        step();
        bus.start = 1'b1; step(); bus.start = 1'b0;
        send_word(16'h0F0E, 0);
        check("postrst_wr_en", bus.lut_wr_en, 1);
        check("postrst_wr_addr", bus.lut_wr_addr, 0);
        check("postrst_wr_data", bus.lut_wr_data, 16'h0F0E);
        check("postrst_count", wr_addr_q.size(), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
